mux_varredura_n: RTL
====================

# mux_varredura_n

Parametrised, registered N-to-1 multiplexer for the memory-game datapath. It selects one of N W-bit channels either directly from `SEL` (manual mode) or through an internal channel pointer that advances on a `tick` strobe and wraps around (scan mode). Out-of-range selects are flagged and the output is held. It replaces the fixed combinational 2x1 mux wherever the datapath needs a registered output, more than two sources, or automatic stepping through sources, such as LED/sequence playback.

## Interface
Parameters:
- `N`, 4, number of input channels, at least 2, need not be a power of two.
- `W`, 4, width of each channel in bits.
- `SW`, `$clog2(N)`, width of `SEL` and `CANAL`. Derived; never overridden.

Ports:
- `clock`  in  1  single system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `zera`  in  1  synchronous clear, active-high.
- `D`  in  N*W  packed channels; channel k occupies `D[k*W +: W]`.
- `SEL`  in  SW  manual channel select.
- `modo`  in  1  0 selects manual mode, 1 selects scan mode.
- `tick`  in  1  scan advance strobe, one cycle wide. Ignored in manual mode.
- `OUT`  out  W  registered selected data.
- `CANAL`  out  SW  index of the channel currently driving `OUT`.
- `VALIDO`  out  1  `OUT` holds data from a legal channel.
- `ERRO_SEL`  out  1  the last manual sample had `SEL` >= N.
- `FIM`  out  1  one-cycle pulse when the scan wraps from N-1 to 0.

## Operation
- Internal state:
  - channel pointer `ptr` (SW bits), driven directly onto `CANAL`;
  - state register with two states, REPOUSO and ATIVO.
- REPOUSO: the state after `reset` or `zera`. `VALIDO` is 0.
  - REPOUSO -> ATIVO on the first edge on which a legal channel is loaded, in either mode.
- ATIVO: `VALIDO` is 1 while `ERRO_SEL` is 0.
  - ATIVO -> REPOUSO only on `zera` or `reset`.
- Manual mode (`modo`=0), on every edge:
  - if `SEL` < N: `ptr` <= `SEL`, `OUT` <= `D[SEL]`, `ERRO_SEL` <= 0;
  - if `SEL` >= N: `ptr` and `OUT` hold, `ERRO_SEL` <= 1, `VALIDO` <= 0.
  - The range check is only reachable when N is not a power of two. With a power-of-two N, `ERRO_SEL` stays 0.
- Scan mode (`modo`=1):
  - `tick`=1: `ptr` <= (`ptr` == N-1) ? 0 : `ptr`+1, and `OUT` <= D[new `ptr`].
  - `tick`=0: `ptr` holds and `OUT` <= D[`ptr`], so `OUT` tracks live data on the current channel.
  - `ERRO_SEL` <= 0.
  - `FIM` <= 1 only on an edge where `tick`=1 and `ptr` == N-1. Otherwise `FIM` <= 0.
- Mode switches:
  - Manual -> scan: the scan continues from the last legal manual channel, with no jump.
  - Scan -> manual: `SEL` takes effect on the first edge with `modo`=0.
- Priority: `reset` > `zera` > mode logic.
- `zera`=1 sets `ptr`=0, `OUT`=0, `VALIDO`=0, `ERRO_SEL`=0 and `FIM`=0, and enters REPOUSO. `zera` overrides any concurrent `tick`.

## Timing
- Reset (`reset`=0): immediate and asynchronous. `OUT`=0, `CANAL`=0, `VALIDO`=0, `ERRO_SEL`=0, `FIM`=0, state is REPOUSO. All outputs hold these values while `reset` is low.
- Release of `reset`: the first sampling edge is the first rising edge after release.
- Latency:
  - In both modes, `OUT`, `CANAL`, `VALIDO` and `ERRO_SEL` reflect the inputs sampled at the previous rising edge (1 cycle).
  - `FIM` is coincident with the `OUT` update for channel 0.
- `tick` held high for K cycles advances the pointer K times, one per cycle. Back-to-back ticks are legal.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-scan: the scan restarts at channel 0 after release, and the next tick selects channel 1.

## Test plan
- Bench settings: N=3, W=4. Channel data D0=4'h5, D1=4'hA, D2=4'hC.
- Reset: hold `reset`=0 for 2 cycles with `SEL`=2 -> `OUT`=0, `CANAL`=0, `VALIDO`=0, `FIM`=0 throughout. The first edge after release gives `OUT`=4'hC, `CANAL`=2, `VALIDO`=1.
- Manual sweep: `modo`=0, `SEL`=0,1,2 on consecutive edges -> `OUT`=5, A, C, each one cycle after its `SEL`. `ERRO_SEL`=0.
- Illegal select: `SEL`=1 then `SEL`=3 -> `OUT` holds 4'hA, `CANAL`=1, `ERRO_SEL`=1, `VALIDO`=0. Then `SEL`=0 -> `OUT`=5, `ERRO_SEL`=0, `VALIDO`=1.
- Scan wrap: from `CANAL`=1, `modo`=1, four single-cycle ticks -> `CANAL`=2,0,1,2 and `OUT`=C,5,A,C. `FIM`=1 exactly on the edge that produces `CANAL`=0.
- Live tracking: in scan mode on channel 2 with `tick`=0, change D2 to 4'h3 -> `OUT`=3 one cycle later, `CANAL` unchanged, `FIM`=0.
- Clear and mid-scan reset: `zera`=1 together with `tick`=1 -> `OUT`=0, `CANAL`=0, `VALIDO`=0, no advance. Then assert `reset` asynchronously between edges during a scan -> outputs go to 0 immediately. After release, the next tick gives `CANAL`=1 and `OUT`=4'hA.

Source files
------------

// File: rtl/mux_varredura_n.sv
// rtl/mux_varredura_n.sv - registered N-to-1 mux with manual select and tick-driven scan
module mux_varredura_n #(
    parameter int  N  = 4,
    parameter int  W  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            zera,
    input  logic [N*W-1:0]  D,
    input  logic [SW-1:0]   SEL,
    input  logic            modo,
    input  logic            tick,
    output logic [W-1:0]    OUT,
    output logic [SW-1:0]   CANAL,
    output logic            VALIDO,
    output logic            ERRO_SEL,
    output logic            FIM
);

    typedef enum logic {
        REPOUSO = 1'b0,
        ATIVO   = 1'b1
    } estado_t;

    // One extra bit so N itself is representable when N is a power of two.
    localparam logic [SW:0]   LP_N    = (SW+1)'(N);
    localparam logic [SW-1:0] LP_LAST = SW'(N - 1);

    estado_t        r_estado;
    logic [SW-1:0]  r_ptr;
    logic [W-1:0]   r_out;
    logic           r_erro;
    logic           r_fim;

    logic           w_sel_legal;
    logic [SW-1:0]  w_ptr_next;
    logic [W-1:0]   w_data;

    // Next channel: SEL in manual mode (if in range), wrapping increment on tick in scan mode.
    always_comb begin
        w_sel_legal = ({1'b0, SEL} < LP_N);
        w_ptr_next  = r_ptr;
        if (modo) begin
            if (tick) begin
                w_ptr_next = (r_ptr == LP_LAST) ? '0 : r_ptr + SW'(1);
            end
        end else if (w_sel_legal) begin
            w_ptr_next = SEL;
        end
    end

    // Channel mux by comparison loop, so an illegal index can never address outside D.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_ptr_next == SW'(k)) begin
                w_data = D[k*W +: W];
            end
        end
    end

    // State, pointer and output registers; reset beats zera beats the mode logic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= REPOUSO;
            r_ptr    <= '0;
            r_out    <= '0;
            r_erro   <= 1'b0;
            r_fim    <= 1'b0;
        end else if (zera) begin
            r_estado <= REPOUSO;
            r_ptr    <= '0;
            r_out    <= '0;
            r_erro   <= 1'b0;
            r_fim    <= 1'b0;
        end else if (!modo && !w_sel_legal) begin
            // Illegal manual select: pointer and data hold, only the flag moves.
            r_erro   <= 1'b1;
            r_fim    <= 1'b0;
        end else begin
            r_estado <= ATIVO;
            r_ptr    <= w_ptr_next;
            r_out    <= w_data;
            r_erro   <= 1'b0;
            r_fim    <= modo & tick & (r_ptr == LP_LAST);
        end
    end

    assign OUT      = r_out;
    assign CANAL    = r_ptr;
    assign ERRO_SEL = r_erro;
    assign FIM      = r_fim;
    // Decoded from flops only: valid once a legal channel was loaded and the last sample was legal.
    assign VALIDO   = (r_estado == ATIVO) && !r_erro;

endmodule
